multicycle_control_unit: RTL and testbench

Finite-state controller that sequences the shared RISC-V datapath (single ALU, unified instruction/data memory port, register file, immediate unit) over multiple cycles per instruction. It replaces the single-cycle combinational decoder. Each instruction is fetched, decoded and dispatched through execute, memory and write-back states, stalling on a memory ready handshake. It also drives the immediate-format select consumed by the immediate unit.

---
 rtl/multicycle_control_unit_pkg.sv | 96 +++++++++
 rtl/multicycle_control_unit_if.sv | 12 +
 rtl/multicycle_control_unit_opcode_dispatch.sv | 28 ++
 rtl/multicycle_control_unit.sv | 108 ++++++++++
 tb/tb_multicycle_control_unit.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multicycle RISC-V controller: states, opcodes and datapath selects.
// Also holds the per-state Moore control table used by the controller FSM.
package multicycle_pkg;

    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_LUI, S_MEM_ADDR, S_MEM_RD,
        S_MEM_WB, S_MEM_WR, S_ALU_WB, S_BRANCH, S_JAL, S_ILLEGAL
    } state_e;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_e;
    typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_FUNCT} alu_op_e;
    typedef enum logic [1:0] {SRCA_PC, SRCA_RS1, SRCA_OLD_PC} alu_src_a_e;
    typedef enum logic [1:0] {SRCB_RS2, SRCB_IMM, SRCB_FOUR} alu_src_b_e;
    typedef enum logic [1:0] {RES_ALU_OUT, RES_MEM_DATA, RES_ALU} result_src_e;

    typedef struct packed {
        logic        mem_read;
        logic        mem_write;
        logic        i_or_d;
        logic        pc_write;
        logic        reg_write;
        alu_src_a_e  alu_src_a;
        alu_src_b_e  alu_src_b;
        alu_op_e     alu_op;
        result_src_e result_src;
        imm_sel_e    imm_sel;
    } ctrl_t;

    // Moore part only; the ready-qualified FETCH strobes and BRANCH pc_write are added by the top.
    function automatic ctrl_t state_ctrl(state_e s, imm_sel_e mem_imm);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = SRCB_FOUR;
            end
            S_DECODE: begin
                c.alu_src_a = SRCA_OLD_PC;
                c.alu_src_b = SRCB_IMM;
                c.imm_sel   = IMM_B;
            end
            S_EXEC_R: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_op    = ALU_FUNCT;
            end
            S_EXEC_I: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALU_FUNCT;
            end
            S_LUI: begin
                c.alu_src_b = SRCB_IMM;
                c.imm_sel   = IMM_U;
            end
            S_MEM_ADDR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
                c.imm_sel   = mem_imm;
            end
            S_MEM_RD: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.result_src = RES_MEM_DATA;
            end
            S_MEM_WR: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            S_ALU_WB:  c.reg_write = 1'b1;
            S_BRANCH: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_op    = ALU_SUB;
            end
            S_JAL: begin
                c.pc_write  = 1'b1;
                c.alu_src_a = SRCA_OLD_PC;
                c.alu_src_b = SRCB_FOUR;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Unified instruction/data memory handshake between the controller (master) and memory (slave).
interface multicycle_control_unit_if;
    import multicycle_pkg::*;

    logic mem_read_o;
    logic mem_write_o;
    logic i_or_d_o;
    logic mem_ready_i;

    modport master (output mem_read_o, output mem_write_o, output i_or_d_o, input mem_ready_i);
    modport slave  (input mem_read_o, input mem_write_o, input i_or_d_o, output mem_ready_i);
endinterface

// File: rtl/multicycle_control_unit_opcode_dispatch.sv
// Combinational opcode decode: DECODE-state successor and the load/store immediate format.
module opcode_dispatch
    import multicycle_pkg::*;
(
    input  logic [6:0] op_i,
    output state_e     next_state_o,
    output imm_sel_e   mem_imm_sel_o
);

    always_comb begin
        next_state_o  = S_ILLEGAL;
        mem_imm_sel_o = IMM_I;
        case (op_i)
            OP_R:      next_state_o = S_EXEC_R;
            OP_IMM:    next_state_o = S_EXEC_I;
            OP_LUI:    next_state_o = S_LUI;
            OP_LOAD:   next_state_o = S_MEM_ADDR;
            OP_STORE: begin
                next_state_o  = S_MEM_ADDR;
                mem_imm_sel_o = IMM_S;
            end
            OP_BRANCH: next_state_o = S_BRANCH;
            OP_JAL:    next_state_o = S_JAL;
            default:   next_state_o = S_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RISC-V controller sequencing a shared ALU/memory datapath.
// Define MC_PERF_COUNTERS_EN to add cycle_count_o and instret_count_o.
module multicycle_control_unit
    import multicycle_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    multicycle_control_unit_if.master  mem,
    input  logic [6:0]                 op_i,
    input  logic                       zero_i,
    output logic                       ir_write_o,
    output logic                       pc_write_o,
    output logic                       reg_write_o,
    output logic [1:0]                 alu_src_a_o,
    output logic [1:0]                 alu_src_b_o,
    output logic [1:0]                 alu_op_o,
    output logic [1:0]                 result_src_o,
    output logic [2:0]                 imm_sel_o,
    output logic                       illegal_o,
    output logic [3:0]                 state_o
`ifdef MC_PERF_COUNTERS_EN
    ,
    output logic [31:0]                cycle_count_o,
    output logic [31:0]                instret_count_o
`endif
);

    state_e   state_q, state_d;
    state_e   disp_state;
    imm_sel_e disp_imm;
    ctrl_t    ctrl_q, ctrl_out;
    logic     illegal_q;
    logic     fetch_go, branch_go;

    opcode_dispatch u_dispatch (
        .op_i          (op_i),
        .next_state_o  (disp_state),
        .mem_imm_sel_o (disp_imm)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem.mem_ready_i) state_d = S_DECODE;
            S_DECODE:   state_d = disp_state;
            S_EXEC_R, S_EXEC_I, S_LUI, S_JAL: state_d = S_ALU_WB;
            S_MEM_ADDR: state_d = (op_i == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (mem.mem_ready_i) state_d = S_MEM_WB;
            S_MEM_WR:   if (mem.mem_ready_i) state_d = S_FETCH;
            S_MEM_WB, S_ALU_WB, S_BRANCH: state_d = S_FETCH;
            S_ILLEGAL:  state_d = S_ILLEGAL;
            default:    state_d = S_FETCH;
        endcase
    end

    // Control word is registered alongside the state it belongs to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            ctrl_q    <= state_ctrl(S_FETCH, IMM_I);
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= state_ctrl(state_d, disp_imm);
            illegal_q <= illegal_q | (state_d == S_ILLEGAL);
        end
    end

    assign ctrl_out  = reset ? '0 : ctrl_q;
    assign fetch_go  = ~reset & (state_q == S_FETCH) & mem.mem_ready_i;
    assign branch_go = ~reset & (state_q == S_BRANCH) & zero_i;

    assign mem.mem_read_o  = ctrl_out.mem_read;
    assign mem.mem_write_o = ctrl_out.mem_write;
    assign mem.i_or_d_o    = ctrl_out.i_or_d;
    assign ir_write_o      = fetch_go;
    assign pc_write_o      = ctrl_out.pc_write | fetch_go | branch_go;
    assign reg_write_o     = ctrl_out.reg_write;
    assign alu_src_a_o     = ctrl_out.alu_src_a;
    assign alu_src_b_o     = ctrl_out.alu_src_b;
    assign alu_op_o        = ctrl_out.alu_op;
    assign result_src_o    = ctrl_out.result_src;
    assign imm_sel_o       = ctrl_out.imm_sel;
    assign illegal_o       = illegal_q;
    assign state_o         = state_q;

`ifdef MC_PERF_COUNTERS_EN
    logic [31:0] cycle_q, instret_q;
    logic        retire;

    assign retire = (state_d == S_FETCH) &&
                    (state_q inside {S_MEM_WB, S_MEM_WR, S_ALU_WB, S_BRANCH});

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else if (state_q != S_ILLEGAL) begin
            cycle_q <= cycle_q + 32'd1;
            if (retire) instret_q <= instret_q + 32'd1;
        end
    end

    assign cycle_count_o   = cycle_q;
    assign instret_count_o = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: per-instruction state/output model with random waits and inputs.
module tb_multicycle_control_unit;
    import multicycle_pkg::*;

    logic       clk;
    logic       reset;
    logic [6:0] op_i;
    logic       zero_i;
    logic       ir_write_o, pc_write_o, reg_write_o, illegal_o;
    logic [1:0] alu_src_a_o, alu_src_b_o, alu_op_o, result_src_o;
    logic [2:0] imm_sel_o;
    logic [3:0] state_o;
`ifdef MC_PERF_COUNTERS_EN
    logic [31:0] cycle_count_o, instret_count_o;
`endif

    int checks   = 0;
    int failures = 0;

    logic [6:0] legal [7] = '{7'h33, 7'h13, 7'h37, 7'h03, 7'h23, 7'h63, 7'h6F};

    multicycle_control_unit_if mif ();

    multicycle_control_unit dut (
        .clk          (clk),
        .reset        (reset),
        .mem          (mif),
        .op_i         (op_i),
        .zero_i       (zero_i),
        .ir_write_o   (ir_write_o),
        .pc_write_o   (pc_write_o),
        .reg_write_o  (reg_write_o),
        .alu_src_a_o  (alu_src_a_o),
        .alu_src_b_o  (alu_src_b_o),
        .alu_op_o     (alu_op_o),
        .result_src_o (result_src_o),
        .imm_sel_o    (imm_sel_o),
        .illegal_o    (illegal_o),
        .state_o      (state_o)
`ifdef MC_PERF_COUNTERS_EN
        ,
        .cycle_count_o   (cycle_count_o),
        .instret_count_o (instret_count_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [21:0] obs_vec;
    assign obs_vec = {state_o, illegal_o, mif.mem_read_o, mif.mem_write_o, mif.i_or_d_o,
                      ir_write_o, pc_write_o, reg_write_o, alu_src_a_o, alu_src_b_o,
                      alu_op_o, result_src_o, imm_sel_o};

    // Output table of each state, written from the controller's documented behaviour.
    function automatic logic [21:0] expect_out(state_e s, logic [6:0] op, logic z, logic rdy);
        logic mr, mw, iod, irw, pcw, rw, ill;
        logic [1:0] sa, sb, ao, rs;
        logic [2:0] im;
        {mr, mw, iod, irw, pcw, rw, ill} = '0;
        {sa, sb, ao, rs} = '0;
        im = '0;
        case (s)
            S_FETCH:    begin mr = 1; sb = 2; irw = rdy; pcw = rdy; end
            S_DECODE:   begin sa = 2; sb = 1; im = 2; end
            S_EXEC_R:   begin sa = 1; ao = 2; end
            S_EXEC_I:   begin sa = 1; sb = 1; ao = 2; end
            S_LUI:      begin sb = 1; im = 3; end
            S_MEM_ADDR: begin sa = 1; sb = 1; im = (op == 7'h23) ? 3'd1 : 3'd0; end
            S_MEM_RD:   begin mr = 1; iod = 1; end
            S_MEM_WB:   begin rw = 1; rs = 1; end
            S_MEM_WR:   begin mw = 1; iod = 1; end
            S_ALU_WB:   rw = 1;
            S_BRANCH:   begin sa = 1; ao = 1; pcw = z; end
            S_JAL:      begin pcw = 1; sa = 2; sb = 2; end
            S_ILLEGAL:  ill = 1;
            default:    ill = 0;
        endcase
        return {s, ill, mr, mw, iod, irw, pcw, rw, sa, sb, ao, rs, im};
    endfunction

    // zsel: 0/1 force zero_i, 2 random. max_cyc: 0 runs the whole instruction.
    task automatic run_instr(input logic [6:0] op, input int fw, input int mw,
                             input int zsel, input int max_cyc);
        state_e seq[$];
        int     rq[$];
        int     n;
        logic   rdy;
        logic [21:0] exp_v;
        for (int i = 0; i <= fw; i++) begin seq.push_back(S_FETCH); rq.push_back(i == fw ? 1 : 0); end
        seq.push_back(S_DECODE); rq.push_back(2);
        case (op)
            7'h33: begin seq.push_back(S_EXEC_R); seq.push_back(S_ALU_WB); end
            7'h13: begin seq.push_back(S_EXEC_I); seq.push_back(S_ALU_WB); end
            7'h37: begin seq.push_back(S_LUI);    seq.push_back(S_ALU_WB); end
            7'h6F: begin seq.push_back(S_JAL);    seq.push_back(S_ALU_WB); end
            7'h63: seq.push_back(S_BRANCH);
            7'h03: begin
                seq.push_back(S_MEM_ADDR); rq.push_back(2);
                for (int i = 0; i <= mw; i++) begin seq.push_back(S_MEM_RD); rq.push_back(i == mw ? 1 : 0); end
                seq.push_back(S_MEM_WB);
            end
            7'h23: begin
                seq.push_back(S_MEM_ADDR); rq.push_back(2);
                for (int i = 0; i <= mw; i++) begin seq.push_back(S_MEM_WR); rq.push_back(i == mw ? 1 : 0); end
            end
            default: for (int i = 0; i < 10; i++) seq.push_back(S_ILLEGAL);
        endcase
        while (rq.size() < seq.size()) rq.push_back(2);
        n = seq.size();
        if (max_cyc != 0 && max_cyc < n) n = max_cyc;
        for (int c = 0; c < n; c++) begin
            op_i   = op;
            zero_i = (zsel == 2) ? 1'($urandom_range(0, 1)) : (zsel != 0);
            rdy    = (rq[c] == 2) ? 1'($urandom_range(0, 1)) : (rq[c] != 0);
            mif.mem_ready_i = rdy;
            #1;
            exp_v = expect_out(seq[c], op, zero_i, rdy);
            checks++;
            assert (obs_vec === exp_v) else begin
                failures++;
                $error("FAIL cycle op=%h idx=%0d obs=%h exp=%h", op, c, obs_vec, exp_v);
            end
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mif.mem_ready_i = 1'b1;
        zero_i = 1'b1;
        #1;
        checks++;
        assert ({mif.mem_read_o, mif.mem_write_o, mif.i_or_d_o, ir_write_o, pc_write_o, reg_write_o} === 6'b0)
        else begin
            failures++;
            $error("FAIL rst_strobes obs=%b exp=%b",
                   {mif.mem_read_o, mif.mem_write_o, mif.i_or_d_o, ir_write_o, pc_write_o, reg_write_o}, 6'b0);
        end
        @(negedge clk);
        #1;
        checks++;
        assert ({state_o, illegal_o, mif.mem_write_o} === {S_FETCH, 2'b00}) else begin
            failures++;
            $error("FAIL rst_state obs=%h exp=%h", {state_o, illegal_o, mif.mem_write_o}, {S_FETCH, 2'b00});
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        op_i = '0;
        zero_i = 1'b0;
        mif.mem_ready_i = 1'b0;
        @(negedge clk);
        do_reset();

        run_instr(7'h13, 0, 0, 2, 0);
        run_instr(7'h03, 0, 2, 2, 0);
        run_instr(7'h63, 0, 0, 1, 0);
        run_instr(7'h63, 0, 0, 0, 0);
        run_instr(7'h23, 0, 0, 2, 0);
        run_instr(7'h6F, 1, 0, 2, 0);
        run_instr(7'h37, 0, 0, 2, 0);
        run_instr(7'h33, 2, 0, 2, 0);
        for (int i = 0; i < 60; i++)
            run_instr(legal[$urandom_range(0, 6)], $urandom_range(0, 2), $urandom_range(0, 2), 2, 0);

        // Abort a store while it is waiting in MEM_WR.
        run_instr(7'h23, 0, 3, 2, 4);
        #1;
        checks++;
        assert (state_o === S_MEM_WR) else begin
            failures++;
            $error("FAIL pre_abort_state obs=%h exp=%h", state_o, S_MEM_WR);
        end
        do_reset();
        run_instr(7'h13, 0, 0, 2, 0);

        run_instr(7'h7F, 1, 0, 2, 0);
        do_reset();
        run_instr(7'h13, 0, 0, 2, 0);

`ifdef MC_PERF_COUNTERS_EN
        do_reset();
        for (int i = 0; i < 3; i++) run_instr(7'h13, 0, 0, 2, 0);
        checks++;
        assert (cycle_count_o === 32'd12) else begin
            failures++;
            $error("FAIL cycle_count obs=%0d exp=%0d", cycle_count_o, 12);
        end
        checks++;
        assert (instret_count_o === 32'd3) else begin
            failures++;
            $error("FAIL instret_count obs=%0d exp=%0d", instret_count_o, 3);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
